bsg_circular_ptr_reader: RTL and testbench

//  Read-side controller for a multi-entry circular buffer whose write side advances by wr_add_i entries/cycle.

---
 rtl/bsg_circular_ptr_pkg.sv | 20 ++
 rtl/bsg_circular_ptr_mod_add.sv | 26 ++
 rtl/bsg_circular_ptr_reader.sv | 112 +++++++++++
 tb/tb_bsg_circular_ptr_reader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/bsg_circular_ptr_pkg.sv
// Shared helpers for the circular-buffer read and write pointers.
// Width functions and the protocol error cause encoding.
package bsg_circular_ptr_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_OVF,
    ERR_ADD_RANGE,
    ERR_DEQ_RANGE
  } err_cause_e;

  function automatic int ptr_width(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

  function automatic int cnt_width(input int slots);
    return $clog2(slots + 1);
  endfunction

endpackage

// File: rtl/bsg_circular_ptr_mod_add.sv
// Combinational (ptr + inc) mod slots_p with a single conditional subtract.
// Valid whenever inc <= slots_p, which holds for both pointer sides.
module bsg_circular_ptr_mod_add
  import bsg_circular_ptr_pkg::*;
#(
  parameter int slots_p = 32,
  parameter int inc_w   = 3,
  localparam int ptr_w  = ptr_width(slots_p)
) (
  input  logic [ptr_w-1:0] i_ptr,
  input  logic [inc_w-1:0] i_inc,
  output logic [ptr_w-1:0] o_ptr
);

  localparam int sum_w = ((ptr_w > inc_w) ? ptr_w : inc_w) + 1;
  localparam logic [sum_w-1:0] SLOTS = sum_w'(slots_p);

  logic [sum_w-1:0] w_sum;
  logic [sum_w-1:0] w_wrap;

  assign w_sum  = sum_w'(i_ptr) + sum_w'(i_inc);
  assign w_wrap = w_sum - SLOTS;
  assign o_ptr  = (w_sum >= SLOTS) ? w_wrap[ptr_w-1:0]
                                   : w_sum[ptr_w-1:0];

endmodule

// File: rtl/bsg_circular_ptr_reader.sv
// Read-side pointer/occupancy controller for a multi-entry circular buffer.
// Define BSG_CIRCULAR_PTR_READER_ERR_EN for the sticky protocol error flag.
module bsg_circular_ptr_reader
  import bsg_circular_ptr_pkg::*;
#(
  parameter int slots_p   = 32,
  parameter int max_add_p = 5,
  parameter int max_deq_p = 5,
  localparam int ptr_w    = ptr_width(slots_p),
  localparam int add_w    = $clog2(max_add_p + 1),
  localparam int deq_w    = $clog2(max_deq_p + 1),
  localparam int cnt_w    = cnt_width(slots_p)
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic [add_w-1:0] wr_add_i,
  input  logic [deq_w-1:0] deq_req_i,
  output logic [deq_w-1:0] deq_grant_o,
  input  logic             yumi_i,
  output logic [ptr_w-1:0] rptr_o,
  output logic [ptr_w-1:0] n_rptr_o,
  output logic [cnt_w-1:0] count_o,
  output logic [cnt_w-1:0] space_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             err_o
);

  localparam int sum_w = cnt_w + 1;
  localparam logic [sum_w-1:0] SLOTS = sum_w'(slots_p);

  logic [ptr_w-1:0] r_rptr;
  logic [cnt_w-1:0] r_count;
  logic [deq_w-1:0] w_grant;
  logic [deq_w-1:0] w_take;
  logic [ptr_w-1:0] w_nrptr;
  logic [sum_w-1:0] w_sum;
  logic [cnt_w-1:0] w_count_n;

  // Grant looks only at registered occupancy: no same-cycle bypass.
  assign w_grant = (sum_w'(deq_req_i) <= sum_w'(r_count))
                 ? deq_req_i
                 : r_count[deq_w-1:0];
  assign w_take  = yumi_i ? w_grant : '0;

  bsg_circular_ptr_mod_add #(
    .slots_p (slots_p),
    .inc_w   (deq_w)
  ) u_mod_add (
    .i_ptr (r_rptr),
    .i_inc (w_take),
    .o_ptr (w_nrptr)
  );

  assign w_sum = sum_w'(r_count) + sum_w'(wr_add_i)
               - sum_w'(w_take);
  assign w_count_n = (w_sum > SLOTS) ? SLOTS[cnt_w-1:0]
                                     : w_sum[cnt_w-1:0];

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_rptr  <= w_nrptr;
      r_count <= w_count_n;
    end
  end

  assign deq_grant_o = w_grant;
  assign rptr_o      = r_rptr;
  assign n_rptr_o    = w_nrptr;
  assign count_o     = r_count;
  assign space_o     = SLOTS[cnt_w-1:0] - r_count;
  assign empty_o     = (r_count == '0);
  assign full_o      = (r_count == SLOTS[cnt_w-1:0]);

`ifdef BSG_CIRCULAR_PTR_READER_ERR_EN
  err_cause_e w_cause;
  logic       r_err;

  // A full buffer may still accept writes matched by a same-cycle take.
  always_comb begin
    w_cause = ERR_NONE;
    if (sum_w'(wr_add_i) > sum_w'(max_add_p))
      w_cause = ERR_ADD_RANGE;
    else if (sum_w'(deq_req_i) > sum_w'(max_deq_p))
      w_cause = ERR_DEQ_RANGE;
    else if (w_sum > SLOTS)
      w_cause = ERR_OVF;
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i)
      r_err <= 1'b0;
    else if (w_cause != ERR_NONE)
      r_err <= 1'b1;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset_i && w_cause != ERR_NONE)
      $error("bsg_circular_ptr_reader: %s", w_cause.name());
  end
`endif

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_circular_ptr_reader.sv
// Scoreboard bench for bsg_circular_ptr_reader (slots 32 and slots 24).
// Directed vectors push expected outputs; a negedge monitor checks them.
module tb_bsg_circular_ptr_reader;

`ifdef BSG_CIRCULAR_PTR_READER_ERR_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  logic [2:0] a_wr = '0, a_req = '0;
  logic       a_y = 1'b0;
  logic [2:0] a_grant;
  logic [4:0] a_rptr, a_nrptr;
  logic [5:0] a_cnt, a_space;
  logic       a_empty, a_full, a_err;

  logic [2:0] b_wr = '0, b_req = '0;
  logic       b_y = 1'b0;
  logic [2:0] b_grant;
  logic [4:0] b_rptr, b_nrptr;
  logic [4:0] b_cnt, b_space;
  logic       b_empty, b_full, b_err;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  bsg_circular_ptr_reader #(
    .slots_p (32), .max_add_p (5), .max_deq_p (5)
  ) u_dut (
    .clk (clk), .reset_i (reset_i),
    .wr_add_i (a_wr), .deq_req_i (a_req),
    .deq_grant_o (a_grant), .yumi_i (a_y),
    .rptr_o (a_rptr), .n_rptr_o (a_nrptr),
    .count_o (a_cnt), .space_o (a_space),
    .empty_o (a_empty), .full_o (a_full),
    .err_o (a_err)
  );

  bsg_circular_ptr_reader #(
    .slots_p (24), .max_add_p (5), .max_deq_p (5)
  ) u_dut24 (
    .clk (clk), .reset_i (reset_i),
    .wr_add_i (b_wr), .deq_req_i (b_req),
    .deq_grant_o (b_grant), .yumi_i (b_y),
    .rptr_o (b_rptr), .n_rptr_o (b_nrptr),
    .count_o (b_cnt), .space_o (b_space),
    .empty_o (b_empty), .full_o (b_full),
    .err_o (b_err)
  );

  typedef struct {
    string name;
    int    cyc;
    int    d;
    int    grant;
    int    rptr;
    int    nrptr;
    int    cnt;
    int    err;
  } exp_t;

  exp_t q[$];

  task automatic drive(
    input int d, input int wr, input int req, input int y,
    input string nm, input int g, input int rp,
    input int nrp, input int cn, input int er
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    a_wr = '0; a_req = '0; a_y = 1'b0;
    b_wr = '0; b_req = '0; b_y = 1'b0;
    if (d == 0) begin
      a_wr = 3'(wr); a_req = 3'(req); a_y = y[0];
    end else begin
      b_wr = 3'(wr); b_req = 3'(req); b_y = y[0];
    end
    e.name = nm; e.cyc = cyc; e.d = d;
    e.grant = g; e.rptr = rp; e.nrptr = nrp;
    e.cnt = cn; e.err = er;
    q.push_back(e);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #1;
    reset_i = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int sl, g, rp, nrp, cn, sp, em, fu, er;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      if (e.d == 0) begin
        sl = 32; g = a_grant; rp = a_rptr; nrp = a_nrptr;
        cn = a_cnt; sp = a_space; em = a_empty;
        fu = a_full; er = a_err;
      end else begin
        sl = 24; g = b_grant; rp = b_rptr; nrp = b_nrptr;
        cn = b_cnt; sp = b_space; em = b_empty;
        fu = b_full; er = b_err;
      end
      n_tests++;
      if (e.cyc != cyc || g != e.grant || rp != e.rptr ||
          nrp != e.nrptr || cn != e.cnt ||
          sp != sl - e.cnt || em != int'(e.cnt == 0) ||
          fu != int'(e.cnt == sl) || er != e.err) begin
        n_fail++;
        $display({"FAIL %s: got grant=%0d rptr=%0d nrptr=%0d ",
                  "cnt=%0d space=%0d empty=%0d full=%0d err=%0d; ",
                  "want grant=%0d rptr=%0d nrptr=%0d cnt=%0d ",
                  "space=%0d empty=%0d full=%0d err=%0d"},
                 e.name, g, rp, nrp, cn, sp, em, fu, er,
                 e.grant, e.rptr, e.nrptr, e.cnt, sl - e.cnt,
                 int'(e.cnt == 0), int'(e.cnt == sl), e.err);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    // reset state, then write 5 / read 5
    drive(0, 5, 5, 1, "rst_grant0", 0, 0, 0, 0, 0);
    drive(0, 0, 5, 1, "deq5", 5, 0, 5, 5, 0);
    drive(0, 5, 5, 0, "drained", 0, 5, 5, 0, 0);
    drive(0, 5, 4, 1, "rw_same", 4, 5, 9, 5, 0);
    drive(0, 1, 0, 0, "idle", 0, 9, 9, 6, 0);
    drive(0, 3, 2, 1, "pre_reset", 2, 9, 11, 7, 0);
    mid_reset();
    drive(0, 5, 0, 0, "post_reset", 0, 0, 0, 0, 0);
    // fill to 32
    for (int i = 1; i <= 5; i++)
      drive(0, 5, 0, 0, "fill", 0, 0, 0, 5 * i, 0);
    drive(0, 2, 0, 0, "fill30", 0, 0, 0, 30, 0);
    drive(0, 5, 5, 1, "full_rw", 5, 0, 5, 32, 0);
    drive(0, 0, 5, 0, "full_noyumi", 5, 5, 5, 32, 0);
    mid_reset();
    drive(0, 3, 0, 0, "reset2", 0, 0, 0, 0, 0);
    drive(0, 2, 3, 0, "no_yumi", 3, 0, 0, 3, 0);
    for (int i = 0; i < 5; i++)
      drive(0, 5, 5, 1, "stream", 5, 5 * i, 5 * i + 5, 5, 0);
    drive(0, 4, 5, 1, "to30", 5, 25, 30, 5, 0);
    drive(0, 0, 5, 1, "wrap32", 4, 30, 2, 4, 0);
    for (int i = 0; i < 6; i++)
      drive(0, 5, 0, 0, "fill_err", 0, 2, 2, 5 * i, 0);
    drive(0, 5, 0, 0, "ovf", 0, 2, 2, 30, 0);
    drive(0, 0, 0, 0, "sat", 0, 2, 2, 32, ERR_ON);
    drive(0, 0, 0, 0, "sticky", 0, 2, 2, 32, ERR_ON);
    mid_reset();
    drive(0, 0, 0, 0, "err_clr", 0, 0, 0, 0, 0);
    // slots_p = 24 wrap
    drive(1, 5, 0, 0, "b_fill", 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      drive(1, 5, 5, 1, "b_stream", 5, 5 * i, 5 * i + 5, 5, 0);
    drive(1, 1, 2, 1, "b_to22", 2, 20, 22, 5, 0);
    drive(1, 0, 5, 1, "b_wrap24", 4, 22, 2, 4, 0);
    drive(1, 0, 0, 0, "b_empty", 0, 2, 2, 0, 0);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
